// File: rtl/board_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : board_pkg
//  Purpose  : Shared register offsets, 7-segment glyph table and hex decoder
//             for the board I/O peripheral.
//  Revision : 1.0  initial release
// ============================================================================
package board_pkg;

  // Register offsets inside the 16-word window
  localparam logic [3:0] KEY_STATE = 4'd0;
  localparam logic [3:0] KEY_EVENT = 4'd1;
  localparam logic [3:0] SW        = 4'd2;
  localparam logic [3:0] LEDG      = 4'd3;
  localparam logic [3:0] LEDR      = 4'd4;
  localparam logic [3:0] HEX_LO    = 4'd5;
  localparam logic [3:0] HEX_HI    = 4'd6;
  localparam logic [3:0] HEX_BLANK = 4'd7;

  // Active-low segments, bit 0 = segment a ... bit 6 = segment g
  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_BLANK = 7'h7F;

  // Glyphs 0-9, A, b, C, d, E, F (active-low)
  localparam seg7_t SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Nibble to segment pattern, forced dark when the digit is blanked
  function automatic seg7_t hex_to_seg(input logic [3:0] nib, input logic blank);
    return blank ? SEG_BLANK : SEG_LUT[nib];
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : key_debounce
//  Purpose  : One pushbutton: two-FF synchroniser on the inverted (active-low)
//             pin, a restart-on-bounce stability counter, the accepted level
//             and a one-cycle rise indication aligned with its update.
//  Revision : 1.0  initial release
// ============================================================================
module key_debounce
  import board_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 24000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic stable,
  output logic rise
);

  localparam int             CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta_q, meta_d;
  logic          sync_q, sync_d;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Next state: any agreement with the stable level restarts the count
  always_comb begin
    meta_d   = ~key_n;
    sync_d   = meta_q;
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = sync_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // State registers; reset discards any pending transition
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      meta_q   <= meta_d;
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;
  // Asserted on the edge where the accepted level goes 0->1
  assign rise   = stable_d & ~stable_q;

endmodule
`default_nettype wire

// File: rtl/board_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : board_ctrl
//  Purpose  : Board I/O peripheral on the J1 I/O bus: debounced keys with
//             press latching, synchronised switches, LED registers and
//             7-segment digits with per-digit blanking.
//  Revision : 1.0  initial release
// ============================================================================
module board_ctrl
  import board_pkg::*;
#(
  parameter int          NUM_KEYS        = 4,
  parameter int          NUM_SW          = 10,
  parameter int          NUM_HEX         = 4,
  parameter int          NUM_LEDG        = 8,
  parameter int          NUM_LEDR        = 10,
  parameter int          DEBOUNCE_CYCLES = 24000,
  parameter logic [15:0] BASE_ADDR       = 16'h0100
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_KEYS-1:0]  key,
  input  logic [NUM_SW-1:0]    sw,
  output logic [7*NUM_HEX-1:0] hex,
  output logic [NUM_LEDG-1:0]  ledg,
  output logic [NUM_LEDR-1:0]  ledr,
  input  logic [15:0]          io_addr,
  input  logic [15:0]          io_dout,
  input  logic                 io_rd,
  input  logic                 io_wr,
  output logic [15:0]          io_din
);

  logic                 hit;
  logic                 wr_hit;
  logic [3:0]           offset;

  logic [NUM_KEYS-1:0]  key_stable;
  logic [NUM_KEYS-1:0]  key_rise;
  logic [NUM_KEYS-1:0]  key_clr;

  logic [NUM_SW-1:0]    sw_meta_q, sw_sync_q;
  logic [NUM_KEYS-1:0]  event_q, event_d;
  logic [NUM_LEDG-1:0]  ledg_q, ledg_d;
  logic [NUM_LEDR-1:0]  ledr_q, ledr_d;
  logic [4*NUM_HEX-1:0] nib_q, nib_d;
  logic [NUM_HEX-1:0]   blank_q, blank_d;
  logic [31:0]          nib_ext;
  logic [15:0]          rdata;

  // Reads are purely combinational, so the read strobe carries no meaning
  logic unused_rd;
  assign unused_rd = io_rd;

  assign hit    = (io_addr[15:4] == BASE_ADDR[15:4]);
  assign offset = io_addr[3:0];
  assign wr_hit = io_wr & hit;

  // One debouncer per pushbutton
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_debounce (
      .clk    (clk),
      .reset  (reset),
      .key_n  (key[i]),
      .stable (key_stable[i]),
      .rise   (key_rise[i])
    );
  end

  // Register write decode; a new press beats a same-cycle W1C
  always_comb begin
    key_clr = (wr_hit && offset == KEY_EVENT) ? io_dout[NUM_KEYS-1:0] : '0;
    event_d = key_rise | (event_q & ~key_clr);
    ledg_d  = ledg_q;
    ledr_d  = ledr_q;
    nib_d   = nib_q;
    blank_d = blank_q;
    if (wr_hit && offset == LEDG)      ledg_d  = io_dout[NUM_LEDG-1:0];
    if (wr_hit && offset == LEDR)      ledr_d  = io_dout[NUM_LEDR-1:0];
    if (wr_hit && offset == HEX_BLANK) blank_d = io_dout[NUM_HEX-1:0];
    // Digits 0..3 live in HEX_LO, 4..7 in HEX_HI; absent digits are dropped
    for (int i = 0; i < NUM_HEX; i++) begin
      if (wr_hit && offset == ((i < 4) ? HEX_LO : HEX_HI)) begin
        nib_d[4*i +: 4] = io_dout[4*(i % 4) +: 4];
      end
    end
  end

  // Register file and switch synchroniser
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      event_q   <= '0;
      ledg_q    <= '0;
      ledr_q    <= '0;
      nib_q     <= '0;
      blank_q   <= '1;
    end else begin
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
      event_q   <= event_d;
      ledg_q    <= ledg_d;
      ledr_q    <= ledr_d;
      nib_q     <= nib_d;
      blank_q   <= blank_d;
    end
  end

  // Read mux; zero outside the window so the bus can OR the slaves together
  always_comb begin
    nib_ext                  = '0;
    nib_ext[4*NUM_HEX-1:0]   = nib_q;
    rdata                    = '0;
    if (hit) begin
      case (offset)
        KEY_STATE: rdata[NUM_KEYS-1:0] = key_stable;
        KEY_EVENT: rdata[NUM_KEYS-1:0] = event_q;
        SW:        rdata[NUM_SW-1:0]   = sw_sync_q;
        LEDG:      rdata[NUM_LEDG-1:0] = ledg_q;
        LEDR:      rdata[NUM_LEDR-1:0] = ledr_q;
        HEX_LO:    rdata               = nib_ext[15:0];
        HEX_HI:    rdata               = nib_ext[31:16];
        HEX_BLANK: rdata[NUM_HEX-1:0]  = blank_q;
        default:   rdata               = '0;
      endcase
    end
  end

  assign io_din = rdata;
  assign ledg   = ledg_q;
  assign ledr   = ledr_q;

  // Segment drivers per digit
  for (genvar i = 0; i < NUM_HEX; i++) begin : g_hex
    assign hex[7*i +: 7] = hex_to_seg(nib_q[4*i +: 4], blank_q[i]);
  end

endmodule
`default_nettype wire

// File: tb/tb_board_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_board_ctrl
//  Purpose  : Directed and randomized bench for board_ctrl with a behavioural
//             reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_board_ctrl;

  localparam int          NK   = 4;
  localparam int          NSW  = 10;
  localparam int          NH   = 4;
  localparam int          NG   = 8;
  localparam int          NR   = 10;
  localparam int          DC   = 8;
  localparam logic [15:0] BASE = 16'h0100;

  // Expected active-low glyphs for nibbles 0..F
  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic            clk = 1'b0;
  logic            reset;
  logic [NK-1:0]   key;
  logic [NSW-1:0]  sw;
  logic [7*NH-1:0] hex;
  logic [NG-1:0]   ledg;
  logic [NR-1:0]   ledr;
  logic [15:0]     io_addr, io_dout, io_din;
  logic            io_rd, io_wr;

  always #5 clk = ~clk;

  board_ctrl #(
    .NUM_KEYS        (NK),
    .NUM_SW          (NSW),
    .NUM_HEX         (NH),
    .NUM_LEDG        (NG),
    .NUM_LEDR        (NR),
    .DEBOUNCE_CYCLES (DC),
    .BASE_ADDR       (BASE)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .key     (key),
    .sw      (sw),
    .hex     (hex),
    .ledg    (ledg),
    .ledr    (ledr),
    .io_addr (io_addr),
    .io_dout (io_dout),
    .io_rd   (io_rd),
    .io_wr   (io_wr),
    .io_din  (io_din)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  logic chk_en  = 1'b0;

  // ---------------- behavioural model ----------------
  logic [NK-1:0]  m_stable, m_event, m_kp1, m_kp2, m_new, m_clr;
  logic [NSW-1:0] m_sp1, m_sp2;
  logic [NG-1:0]  m_ledg;
  logic [NR-1:0]  m_ledr;
  logic [3:0]     m_nib [NH];
  logic [NH-1:0]  m_blank;
  logic [NK-1:0]  m_hist [$];   // synchronised key levels seen at recent edges
  bit             m_flip;

  // A key level is accepted once the last DC synchronised samples all
  // disagree with the currently accepted level.
  task automatic model_step();
    if (reset) begin
      m_stable = '0; m_event = '0; m_kp1 = '0; m_kp2 = '0;
      m_sp1 = '0; m_sp2 = '0; m_ledg = '0; m_ledr = '0; m_blank = '1;
      for (int i = 0; i < NH; i++) m_nib[i] = 4'h0;
      m_hist.delete();
    end else begin
      m_hist.push_back(m_kp2);
      if (m_hist.size() > DC) void'(m_hist.pop_front());
      m_new = m_stable;
      if (m_hist.size() == DC) begin
        for (int k = 0; k < NK; k++) begin
          m_flip = 1'b1;
          foreach (m_hist[j]) if (m_hist[j][k] == m_stable[k]) m_flip = 1'b0;
          if (m_flip) m_new[k] = ~m_stable[k];
        end
      end
      m_clr = '0;
      if (io_wr && io_addr[15:4] == BASE[15:4]) begin
        case (io_addr[3:0])
          4'd1: m_clr  = io_dout[NK-1:0];
          4'd3: m_ledg = io_dout[NG-1:0];
          4'd4: m_ledr = io_dout[NR-1:0];
          4'd5: for (int i = 0; i < NH && i < 4; i++) m_nib[i] = io_dout[4*i +: 4];
          4'd6: for (int i = 4; i < NH; i++) m_nib[i] = io_dout[4*(i-4) +: 4];
          4'd7: for (int i = 0; i < NH; i++) m_blank[i] = io_dout[i];
          default: ;
        endcase
      end
      m_event  = (m_event & ~m_clr) | (m_new & ~m_stable);
      m_stable = m_new;
      m_kp2 = m_kp1; m_kp1 = ~key;
      m_sp2 = m_sp1; m_sp1 = sw;
    end
  endtask

  function automatic logic [15:0] m_read(input logic [15:0] a);
    logic [15:0] r = '0;
    if (a[15:4] != BASE[15:4]) return r;
    case (a[3:0])
      4'd0: for (int i = 0; i < NK; i++)  r[i] = m_stable[i];
      4'd1: for (int i = 0; i < NK; i++)  r[i] = m_event[i];
      4'd2: for (int i = 0; i < NSW; i++) r[i] = m_sp2[i];
      4'd3: for (int i = 0; i < NG; i++)  r[i] = m_ledg[i];
      4'd4: for (int i = 0; i < NR; i++)  r[i] = m_ledr[i];
      4'd5: for (int i = 0; i < NH && i < 4; i++) r[4*i +: 4] = m_nib[i];
      4'd6: for (int i = 4; i < NH; i++)  r[4*(i-4) +: 4] = m_nib[i];
      4'd7: for (int i = 0; i < NH; i++)  r[i] = m_blank[i];
      default: ;
    endcase
    return r;
  endfunction

  function automatic logic [7*NH-1:0] m_hex();
    logic [7*NH-1:0] r;
    for (int i = 0; i < NH; i++) r[7*i +: 7] = m_blank[i] ? 7'h7F : GLYPH[m_nib[i]];
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Every-cycle comparison of all outputs against the model
  initial forever begin
    @(negedge clk);
    #2;
    if (chk_en) begin
      check("hex",    32'(hex),    32'(m_hex()));
      check("ledg",   32'(ledg),   32'(m_ledg));
      check("ledr",   32'(ledr),   32'(m_ledr));
      check("io_din", 32'(io_din), 32'(m_read(io_addr)));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic rd_chk(input logic [15:0] a, input logic [15:0] exp, input string nm);
    @(negedge clk);
    io_addr = a;
    #3;
    check(nm, 32'(io_din), 32'(exp));
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    io_addr = a; io_dout = d; io_wr = 1'b1;
    @(negedge clk);
    io_wr = 1'b0;
  endtask

  int rst_hold;

  initial begin
    reset = 1'b1; key = '1; sw = 10'h3FF;
    io_addr = '0; io_dout = '0; io_rd = 1'b0; io_wr = 1'b0;

    // Reset: three cycles
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    rd_chk(BASE + 16'd1, 16'h0000, "key_event_rst");
    check("hex_rst",  32'(hex),  32'h0FFFFFFF);
    check("ledg_rst", 32'(ledg), 32'h0);
    check("ledr_rst", 32'(ledr), 32'h0);
    reset = 1'b0;
    rd_chk(BASE + 16'd2, 16'h0000, "sw_early");
    rd_chk(BASE + 16'd2, 16'h03FF, "sw_sync");

    // Short bounce is rejected
    @(negedge clk); key[1] = 1'b0;
    repeat (5) @(negedge clk); key[1] = 1'b1;
    repeat (12) @(negedge clk);
    rd_chk(BASE, 16'h0000, "bounce_rejected");

    // Clean press accepted exactly DC+2 edges later
    @(negedge clk); key[1] = 1'b0;
    repeat (8) @(negedge clk);
    rd_chk(BASE, 16'h0000, "debounce_early");
    rd_chk(BASE, 16'h0002, "debounce_accept");
    rd_chk(BASE + 16'd1, 16'h0002, "event_set");

    // W1C, then a clear colliding with a new press
    wr(BASE + 16'd1, 16'h0002);
    rd_chk(BASE + 16'd1, 16'h0000, "w1c_clear");
    @(negedge clk); key[0] = 1'b0;
    repeat (9) @(negedge clk);
    io_addr = BASE + 16'd1; io_dout = 16'h0001; io_wr = 1'b1;
    @(negedge clk); io_wr = 1'b0;
    rd_chk(BASE + 16'd1, 16'h0001, "w1c_set_wins");
    rd_chk(BASE, 16'h0003, "both_pressed");

    // LED width truncation
    wr(BASE + 16'd3, 16'hFFFF);
    wr(BASE + 16'd4, 16'hFFFF);
    rd_chk(BASE + 16'd3, 16'h00FF, "ledg_read");
    check("ledg_out", 32'(ledg), 32'hFF);
    check("ledr_out", 32'(ledr), 32'h3FF);
    rd_chk(BASE + 16'd4, 16'h03FF, "ledr_read");

    // Hex decode and blanking
    wr(BASE + 16'd5, 16'hA0B1);
    wr(BASE + 16'd7, 16'h0004);
    rd_chk(BASE + 16'd5, 16'hA0B1, "hex_lo_read");
    check("hex_d0", 32'(hex[6:0]),   32'h79);
    check("hex_d1", 32'(hex[13:7]),  32'h03);
    check("hex_d2", 32'(hex[20:14]), 32'h7F);
    check("hex_d3", 32'(hex[27:21]), 32'h08);
    rd_chk(BASE + 16'd6, 16'h0000, "hex_hi_absent");
    rd_chk(BASE + 16'd7, 16'h0004, "hex_blank_read");

    // Address decode
    rd_chk(BASE + 16'd9,   16'h0000, "off9_read");
    rd_chk(BASE + 16'h10,  16'h0000, "miss_read");
    wr(BASE + 16'h13, 16'h0000);
    wr(BASE + 16'h14, 16'h0000);
    wr(BASE + 16'd9,  16'h0000);
    rd_chk(BASE + 16'd3, 16'h00FF, "ledg_kept");
    rd_chk(BASE + 16'd4, 16'h03FF, "ledr_kept");

    // Randomized traffic with occasional resets
    key = '1;
    rst_hold = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (rst_hold > 0) begin
        reset = 1'b1; rst_hold--;
      end else begin
        reset = 1'b0;
        if ($urandom_range(0, 399) == 0) rst_hold = $urandom_range(1, 3);
      end
      for (int k = 0; k < NK; k++) if ($urandom_range(0, 11) == 0) key[k] = ~key[k];
      if ($urandom_range(0, 3) == 0) sw = NSW'($urandom);
      io_wr   = ($urandom_range(0, 3) == 0);
      io_rd   = ~io_wr;
      io_dout = 16'($urandom);
      io_addr = ($urandom_range(0, 7) == 0) ? 16'($urandom)
                                            : BASE + 16'($urandom_range(0, 15));
    end
    @(negedge clk);
    reset = 1'b0; io_wr = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/board_ctrl.md
Name: board_ctrl

Overview:
- Parametrised successor of the board I/O peripheral on the J1 I/O bus.
- Owns the pushbuttons, switches, 7-segment digits and LEDs. Keys are synchronised, debounced and press-latched. Switches are synchronised.
- LED and hex-digit registers are CPU-writable. Hex nibbles are decoded to active-low segments, with per-digit blanking.
- Sits beside the USB device controller behind io_bus; the decoded address window is set by parameter.

Parameters:
- NUM_KEYS, 4, pushbutton count (1..16)
- NUM_SW, 10, switch count (1..16)
- NUM_HEX, 4, 7-segment digit count (1..8)
- NUM_LEDG, 8, green LED count (1..16)
- NUM_LEDR, 10, red LED count (1..16)
- DEBOUNCE_CYCLES, 24000, stable cycles before a key level is accepted (1 ms at 24 MHz); must be >=2
- BASE_ADDR, 16'h0100, register window base; bits [3:0] must be 0

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- key  in  NUM_KEYS  raw pushbuttons, active-low, asynchronous
- sw  in  NUM_SW  raw switches, asynchronous
- hex  out  7*NUM_HEX  segments, active-low; digit 0 = hex[6:0], segment a = bit 0
- ledg  out  NUM_LEDG  green LEDs, active-high
- ledr  out  NUM_LEDR  red LEDs, active-high
- io_addr  in  16  CPU I/O address
- io_dout  in  16  CPU write data
- io_rd  in  1  CPU read strobe
- io_wr  in  1  CPU write strobe, single cycle
- io_din  out  16  read data to CPU

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high; no asynchronous reset anywhere.
- Address hit: io_addr[15:4] == BASE_ADDR[15:4]. Offset is io_addr[3:0].
- Register map (offset: register, access):
  - 0: KEY_STATE, RO. Debounced, bit=1 means pressed.
  - 1: KEY_EVENT, R/W1C. Latched press events.
  - 2: SW, RO. Synchronised switches.
  - 3: LEDG, RW.
  - 4: LEDR, RW.
  - 5: HEX_LO, RW. Digits 0..3, nibble i is bits [4i+3:4i].
  - 6: HEX_HI, RW. Digits 4..7.
  - 7: HEX_BLANK, RW. Bit i=1 blanks digit i.
- Width rules:
  - Writes keep the low N bits only; reads zero-extend.
  - Nibbles and blank bits for digits >= NUM_HEX are not stored and read 0.
  - Offsets 8..15 read 0 and ignore writes.
- Read path:
  - io_din is combinational from io_addr (zero latency); io_rd is not required to gate it.
  - io_din = 0 when there is no address hit, so io_bus may OR-combine it.
  - Reads have no side effects.
- Writes take effect on the clk edge where io_wr=1 and the address hits; the new value is visible on outputs the following cycle.
- Key path, per key:
  - Two-FF synchroniser on ~key, so the synchronised value is 1 when pressed.
  - One debounce counter per key, width $clog2(DEBOUNCE_CYCLES).
  - If sync == stable: counter clears to 0.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1 and sync still differs, stable <= sync and the counter clears.
  - Acceptance latency from a clean edge at the key pin: 2 + DEBOUNCE_CYCLES cycles.
  - A bounce back to the stable value at any count restarts the counter from 0.
- Event latch: set on a stable 0->1 transition. Cleared by writing 1 to that bit at offset 1.
  - Set and clear in the same cycle: set wins and the bit stays 1.
- Switch path: two-FF synchroniser only, no debounce.
- Hex decode: nibble 0..F maps to standard glyphs 0-9, A, b, C, d, E, F, active-low. A blanked digit drives 7'h7F.
- Reset values:
  - Synchroniser flops: released (0).
  - stable, counters, KEY_EVENT: 0.
  - SW synchroniser: 0.
  - ledg, ledr: 0.
  - HEX_LO, HEX_HI: 0.
  - HEX_BLANK: all ones, so hex is all-ones (dark).
  - Reset asserted mid-debounce discards the pending transition.
  - A key held through reset is accepted DEBOUNCE_CYCLES+2 cycles after reset deasserts, and raises an event.

Decomposition:
- Package board_pkg holds:
  - Register offset constants: KEY_STATE..HEX_BLANK.
  - The 16-entry seg7_t lookup: typedef logic [6:0] seg7_t, plus the SEG_BLANK constant.
- One sub-module, key_debounce: a single key with synchroniser, counter, stable and rise outputs, parameter DEBOUNCE_CYCLES. Instantiate it NUM_KEYS times in a generate loop.
- Hex decode is a package function, not a module.

Test Plan:
- Reset: assert reset for 3 cycles with key=4'hF, sw=10'h3FF. Expect hex=28'hFFFFFFF and ledg=ledr=0. Reading offset 1 gives 0. Reading offset 2 gives 0 before 2 cycles after reset and 16'h03FF from then on.
- Debounce (DEBOUNCE_CYCLES=8): key[1] low for 5 cycles then high → KEY_STATE stays 0. key[1] held low continuously → KEY_STATE=16'h0002 exactly 10 cycles after the edge, and KEY_EVENT=16'h0002.
- W1C race: with KEY_EVENT=16'h0002, write 16'h0002 to offset 1 → reads 0. Then write 16'h0001 to offset 1 in the cycle key[0]'s stable level rises → bit 0 reads 1.
- LED width: write 16'hFFFF to offset 3 and offset 4 → ledg=8'hFF, ledr=10'h3FF. Readback gives 16'h00FF and 16'h03FF.
- Hex: write HEX_LO=16'hA0B1, HEX_BLANK=16'h0004 → hex[6:0]=7'h79 ("1"), hex[13:7]=7'h03 ("b"), hex[20:14]=7'h7F (blank), hex[27:21]=7'h08 ("A").
- Decode: read at BASE_ADDR+9 and at BASE_ADDR+16'h10 → io_din=0. A write there changes no register.
